// File: rtl/spi_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_command_sequencer
// Description : Frame-level command decoder behind spi_rx. The first byte of
//               each chip-select frame selects a register write burst or a
//               prefetched register read stream.
//               Optional macro: SPI_CMD_SEQ_AUTOINC_EN (burst address increment).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_command_sequencer #(
    parameter int          ADDR_WIDTH  = 7,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  in_data_valid,
    input  logic [7:0]            in_data,
    input  logic                  out_data_ready,
    output logic                  out_data_valid,
    output logic [7:0]            out_data,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  reg_write,
    output logic                  reg_read,
    input  logic [7:0]            reg_rdata,
    output logic                  underrun
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_CMD         = 3'd1,
        S_WRITE       = 3'd2,
        S_READ_FETCH  = 3'd3,
        S_READ_CAP    = 3'd4,
        S_READ_STREAM = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_active_d;
    logic                  r_first;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_tx_buf;
    logic                  r_tx_full;
    logic                  r_out_valid;
    logic [7:0]            r_out_data;
    logic [ADDR_WIDTH-1:0] r_reg_addr;
    logic [7:0]            r_reg_wdata;
    logic                  r_reg_write;
    logic                  r_reg_read;
    logic                  r_underrun;

    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  w_xfer;
    logic                  w_status_mode;
    logic                  w_refetch;

`ifdef SPI_CMD_SEQ_AUTOINC_EN
    assign w_addr_next = r_addr + ADDR_WIDTH'(1);
`else
    assign w_addr_next = r_addr;
`endif

    assign w_xfer        = r_out_valid & out_data_ready;
    assign w_refetch     = (r_state == S_READ_FETCH) || (r_state == S_READ_CAP);
    // Command and turnaround bytes carry the status byte; read data begins at byte 2.
    assign w_status_mode = (r_state == S_CMD) || (r_state == S_WRITE) || (r_first && w_refetch);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_active_d  <= 1'b1;
            r_first     <= 1'b0;
            r_addr      <= '0;
            r_tx_buf    <= 8'h00;
            r_tx_full   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_reg_addr  <= '0;
            r_reg_wdata <= 8'h00;
            r_reg_write <= 1'b0;
            r_reg_read  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_active_d  <= active;
            r_reg_write <= 1'b0;
            r_reg_read  <= 1'b0;
            if (!active) begin
                r_state     <= S_IDLE;
                r_first     <= 1'b0;
                r_tx_full   <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Only a fresh rising edge opens a frame; reset leaves r_active_d high.
                        if (!r_active_d) begin
                            r_state    <= S_CMD;
                            r_underrun <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (in_data_valid) begin
                            r_addr <= in_data[ADDR_WIDTH-1:0];
                            if (in_data[7]) begin
                                r_state    <= S_READ_FETCH;
                                r_first    <= 1'b1;
                                r_reg_read <= 1'b1;
                                r_reg_addr <= in_data[ADDR_WIDTH-1:0];
                            end else begin
                                r_state <= S_WRITE;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (in_data_valid) begin
                            r_reg_write <= 1'b1;
                            r_reg_addr  <= r_addr;
                            r_reg_wdata <= in_data;
                            r_addr      <= w_addr_next;
                        end
                    end
                    S_READ_FETCH: begin
                        r_state <= S_READ_CAP;
                    end
                    S_READ_CAP: begin
                        r_tx_buf  <= reg_rdata;
                        r_tx_full <= 1'b1;
                        r_first   <= 1'b0;
                        r_addr    <= w_addr_next;
                        r_state   <= S_READ_STREAM;
                    end
                    S_READ_STREAM: begin
                        if (w_xfer) begin
                            r_tx_full  <= 1'b0;
                            r_state    <= S_READ_FETCH;
                            r_reg_read <= 1'b1;
                            r_reg_addr <= r_addr;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase

                if (w_status_mode) begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                    end else if (out_data_ready) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= STATUS_BYTE;
                    end
                end else if (r_state == S_READ_STREAM) begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                    end else begin
                        r_out_valid <= r_tx_full;
                        r_out_data  <= r_tx_buf;
                    end
                end else begin
                    r_out_valid <= 1'b0;
                    if (w_refetch && out_data_ready) begin
                        r_underrun <= 1'b1;
                    end
                end
            end
        end
    end

    assign out_data_valid = r_out_valid;
    assign out_data       = r_out_data;
    assign reg_addr       = r_reg_addr;
    assign reg_wdata      = r_reg_wdata;
    assign reg_write      = r_reg_write;
    assign reg_read       = r_reg_read;
    assign underrun       = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_command_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_command_sequencer
// Description : Frame-level randomized bench for spi_command_sequencer with a
//               register-block model and a transaction-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_command_sequencer;

    localparam int         AW   = 7;
    localparam logic [7:0] STAT = 8'hA5;
`ifdef SPI_CMD_SEQ_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          active = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          ready = 1'b0;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_write;
    logic          reg_read;
    logic [7:0]    rdata = 8'h00;
    logic          underrun;

    always #5 clk = ~clk;

    spi_command_sequencer #(.ADDR_WIDTH(AW), .STATUS_BYTE(STAT)) u_dut (
        .clock          (clk),
        .reset          (rst),
        .active         (active),
        .in_data_valid  (in_valid),
        .in_data        (in_data),
        .out_data_ready (ready),
        .out_data_valid (out_valid),
        .out_data       (out_data),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_write      (reg_write),
        .reg_read       (reg_read),
        .reg_rdata      (rdata),
        .underrun       (underrun)
    );

    // Register block: synchronous write, registered read, plus a bench backdoor.
    logic [7:0]    mem [128];
    logic          bd_we = 1'b0;
    logic [6:0]    bd_addr = 7'd0;
    logic [7:0]    bd_data = 8'h00;
    always @(posedge clk) begin
        if (bd_we)          mem[bd_addr] <= bd_data;
        else if (reg_write) mem[reg_addr] <= reg_wdata;
        if (reg_read)       rdata <= mem[reg_addr];
    end

    logic [14:0] wr_q [$];
    logic [6:0]  rd_q [$];
    logic [8:0]  miso_q [$];
    always @(negedge clk) begin
        if (reg_write) wr_q.push_back({reg_addr, reg_wdata});
        if (reg_read)  rd_q.push_back(reg_addr);
    end

    logic [7:0] ref_mem [128];
    logic [7:0] fb [8];
    int         fn;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic poke(input logic [6:0] a, input logic [7:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        tick();
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // One transmit slot: hold ready until a byte is taken (bounded); 9'h100 marks no byte.
    task automatic serve(input bit hold);
        bit         got = 1'b0;
        logic [8:0] b = 9'h100;
        ready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                b = {1'b0, out_data};
            end
            tick();
        end
        if (hold) tick();
        ready = 1'b0;
        miso_q.push_back(b);
    endtask

    task automatic pulse(input logic [7:0] d);
        in_data = d; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [6:0] addr_at(input logic [6:0] a, input int j);
        return a + (AUTO ? 7'(j) : 7'd0);
    endfunction

    task automatic check_frame(input bit fast, input bit urun);
        logic [6:0] a;
        bit         rd;
        int         nslots, expw, expr;
        logic [8:0] em;
        a      = fb[0][6:0];
        rd     = fb[0][7];
        nslots = fast ? 1 : fn;
        expw   = rd ? 0 : fn - 1;
        expr   = !rd ? 0 : (fn < 2 ? 1 : fn - 1);
        chk("miso_count", miso_q.size(), nslots);
        for (int k = 0; k < nslots && k < miso_q.size(); k++) begin
            em = (k < 2 || !rd) ? {1'b0, STAT} : {1'b0, ref_mem[addr_at(a, k - 2)]};
            chk($sformatf("miso[%0d] cmd %0h", k, fb[0]), miso_q[k], em);
        end
        chk("n_writes", wr_q.size(), expw);
        for (int i = 0; i < expw && i < wr_q.size(); i++)
            chk($sformatf("write[%0d]", i), wr_q[i], {addr_at(a, i), fb[i + 1]});
        for (int i = 0; i < expw; i++) ref_mem[addr_at(a, i)] = fb[i + 1];
        chk("n_reads", rd_q.size(), expr);
        for (int i = 0; i < expr && i < rd_q.size(); i++)
            chk($sformatf("read_addr[%0d]", i), rd_q[i], addr_at(a, i));
        chk("underrun", underrun, urun);
        chk("out_valid_after_frame", out_valid, 1'b0);
    endtask

    task automatic run_frame(input bit fast, input bit urun);
        wr_q.delete(); rd_q.delete(); miso_q.delete();
        active = 1'b1;
        for (int k = 0; k < fn; k++) begin
            if (fast && k > 0) begin
                in_data = fb[k]; in_valid = 1'b1;
                tick();
            end else begin
                serve(urun && k == 2);
                wait_n($urandom_range(3, 6));
                pulse(fb[k]);
            end
        end
        in_valid = 1'b0;
        wait_n(4);
        active = 1'b0;
        wait_n(2);
        check_frame(fast, urun);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        // Reset asserted together with a rising active: must stay idle.
        active = 1'b1;
        tick();
        for (int i = 0; i < 128; i++) poke(7'(i), 8'($urandom));
        @(negedge clk);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_data", out_data, 8'h00);
        chk("rst reg_addr", reg_addr, 7'h00);
        chk("rst reg_wdata", reg_wdata, 8'h00);
        chk("rst reg_write", reg_write, 1'b0);
        chk("rst reg_read", reg_read, 1'b0);
        chk("rst underrun", underrun, 1'b0);
        tick();
        rst = 1'b0;
        wr_q.delete(); rd_q.delete();
        tick();
        pulse(8'h00); wait_n(2); pulse(8'h77); wait_n(3);
        chk("rst_rise n_writes", wr_q.size(), 0);
        chk("rst_rise n_reads", rd_q.size(), 0);
        active = 1'b0;
        wait_n(2);

        fn = 3; fb[0] = 8'h05; fb[1] = 8'h11; fb[2] = 8'h22;
        run_frame(1'b0, 1'b0);

        poke(7'd3, 8'h3C); poke(7'd4, 8'h4D);
        fn = 4; fb[0] = 8'h83; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
        run_frame(1'b0, 1'b0);

        fn = 3; fb[0] = 8'h7F; fb[1] = 8'hAA; fb[2] = 8'hBB;
        run_frame(1'b0, 1'b0);

        fn = 4; fb[0] = 8'h82; fb[1] = 8'h01; fb[2] = 8'h02; fb[3] = 8'h03;
        run_frame(1'b0, 1'b0);

        fn = 5; fb[0] = 8'h10; fb[1] = 8'hC1; fb[2] = 8'hC2; fb[3] = 8'hC3; fb[4] = 8'hC4;
        run_frame(1'b1, 1'b0);

        fn = 4; fb[0] = 8'h84; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
        run_frame(1'b0, 1'b1);

        // Abort two cycles after the first data byte, with a byte landing on the fall.
        wr_q.delete();
        active = 1'b1;
        serve(1'b0); wait_n(3); pulse(8'h05); wait_n(3); pulse(8'h11);
        tick();
        active = 1'b0; in_data = 8'h22; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_n(2);
        chk("abort n_writes", wr_q.size(), 1);
        if (wr_q.size() > 0) chk("abort write", wr_q[0], {7'd5, 8'h11});
        chk("abort out_valid", out_valid, 1'b0);
        ref_mem[5] = 8'h11;

        // Reset in the middle of a read frame; the rest of that frame is ignored.
        wr_q.delete(); rd_q.delete();
        active = 1'b1;
        serve(1'b0); wait_n(3); pulse(8'h83); wait_n(4);
        rst = 1'b1; tick(); rst = 1'b0;
        pulse(8'h06); wait_n(2); pulse(8'h99); wait_n(3);
        chk("rst_mid n_writes", wr_q.size(), 0);
        chk("rst_mid n_reads", rd_q.size(), 1);
        chk("rst_mid underrun", underrun, 1'b0);
        active = 1'b0;
        wait_n(2);
        fn = 2; fb[0] = 8'h00; fb[1] = 8'h55;
        run_frame(1'b0, 1'b0);

        for (int f = 0; f < 14; f++) begin
            bit fast;
            fn = $urandom_range(1, 6);
            for (int k = 0; k < fn; k++) fb[k] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) fb[0][6:0] = 7'h7F;
            fast = !fb[0][7] && ($urandom_range(0, 2) == 0);
            run_frame(fast, 1'b0);
        end

        for (int i = 0; i < 128; i += 9) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
